// File: rtl/kypd_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: key map, debounce
// states, scan-result kinds and the key code type.
package kypd_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CNT,
    ST_HELD,
    ST_RELEASE_CNT
  } deb_state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_ONE,
    RES_MULTI
  } scan_res_t;

  // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
  function automatic key_code_t key_map(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Number of asserted bits, saturated at 2 (only none/one/many matters).
  function automatic logic [1:0] low_count(input logic [3:0] v);
    logic [2:0] n;
    n = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    return (n >= 3'd2) ? 2'd2 : n[1:0];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins and key-event outputs of the scanner; master is the scanner,
// slave is the keypad/consumer side.
interface keypad_if;
  logic [3:0]          row_n;
  logic [3:0]          col_n;
  kypd_pkg::key_code_t key_code;
  logic                key_valid;
  logic                key_held;

  modport master (input row_n, output col_n, key_code, key_valid, key_held);
  modport slave  (output row_n, input col_n, key_code, key_valid, key_held);
endinterface

// File: rtl/kypd_sync.sv
// Two-flop synchronizer for the asynchronous row lines; resets to all-ones
// so an unreset keypad reads as "nothing pressed".
module kypd_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, per-scan result accumulation and debounce
// FSM. Define KYPD_REPEAT_EN to add auto-repeat strobes while a key is held.
module keypad_scanner
  import kypd_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic clk,
  input  logic rst_n,
  keypad_if.master kp
);
  localparam int           TW        = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [3:0]    DEB       = 4'(DEBOUNCE_SCANS);

  if (SCAN_TICKS < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0] row_s;
  kypd_sync #(.W(4)) u_sync (.clk(clk), .rst_n(rst_n), .d_i(kp.row_n), .q_o(row_s));

  // Scan timing and result accumulation
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  key_code_t     acc_code_q, acc_code_d;
  logic          res_vld_q, res_vld_d;
  scan_res_t     res_kind_q, res_kind_d;
  key_code_t     res_code_q, res_code_d;

  logic [1:0] n_low, base_cnt, sum_cnt, row_idx;
  logic [2:0] sum_raw;
  key_code_t  code_new;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) if (!row_s[r]) row_idx = 2'(r);
    n_low    = low_count(~row_s);
    base_cnt = (col_q == 2'd0) ? 2'd0 : acc_cnt_q;
    sum_raw  = {1'b0, base_cnt} + {1'b0, n_low};
    sum_cnt  = (sum_raw >= 3'd2) ? 2'd2 : sum_raw[1:0];
    code_new = (n_low == 2'd1) ? key_map(row_idx, col_q)
             : ((col_q == 2'd0) ? 4'h0 : acc_code_q);

    tick_d     = tick_q + 1'b1;
    col_d      = col_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    res_vld_d  = 1'b0;
    res_kind_d = res_kind_q;
    res_code_d = res_code_q;
    if (tick_q == TICK_LAST) begin
      tick_d     = '0;
      col_d      = col_q + 2'd1;
      acc_cnt_d  = sum_cnt;
      acc_code_d = code_new;
      if (col_q == 2'd3) begin
        res_vld_d  = 1'b1;
        res_kind_d = (sum_cnt == 2'd0) ? RES_NONE : (sum_cnt == 2'd1) ? RES_ONE : RES_MULTI;
        res_code_d = code_new;
      end
    end
  end

  // Debounce FSM and registered outputs
  deb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  key_code_t  cand_q, cand_d;
  key_code_t  key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic       res_one, res_match_cand;
`ifdef KYPD_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    cnt_inc        = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    res_one        = (res_kind_q == RES_ONE);
    res_match_cand = res_one && (res_code_q == cand_q);

    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KYPD_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (res_vld_q) begin
      unique case (state_q)
        ST_IDLE: if (res_one) begin
          cand_d  = res_code_q;
          cnt_d   = 4'd1;
          state_d = ST_PRESS_CNT;
          if (DEB == 4'd1) begin
            key_code_d = res_code_q; key_valid_d = 1'b1; key_held_d = 1'b1;
            cnt_d = '0; state_d = ST_HELD;
          end
        end
        ST_PRESS_CNT: begin
          if (res_match_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB) begin
              key_code_d = cand_q; key_valid_d = 1'b1; key_held_d = 1'b1;
              cnt_d = '0; state_d = ST_HELD;
            end
          end else if (res_one) begin
            cand_d = res_code_q;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (res_kind_q == RES_NONE) begin
            cnt_d   = 4'd1;
            state_d = ST_RELEASE_CNT;
            if (DEB == 4'd1) begin
              key_held_d = 1'b0; cnt_d = '0; state_d = ST_IDLE;
            end
          end
`ifdef KYPD_REPEAT_EN
          else if (res_one && res_code_q == key_code_q) begin
            rep_d = rep_q + 1'b1;
            if (rep_q == REP_LAST) begin
              rep_d       = '0;
              key_valid_d = 1'b1;
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
        ST_RELEASE_CNT: begin
          if (res_kind_q == RES_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB) begin
              key_held_d = 1'b0; cnt_d = '0; state_d = ST_IDLE;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end
        end
      endcase
    end
`ifdef KYPD_REPEAT_EN
    if (state_d == ST_HELD && state_q != ST_HELD) rep_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      col_q       <= '0;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      res_vld_q   <= 1'b0;
      res_kind_q  <= RES_NONE;
      res_code_q  <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KYPD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      tick_q      <= tick_d;
      col_q       <= col_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      res_vld_q   <= res_vld_d;
      res_kind_q  <= res_kind_d;
      res_code_q  <= res_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KYPD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign kp.col_n     = ~(4'b0001 << col_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
endmodule
